cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-source handshake plus CDB broadcast bundle for the CDB arbiter.
// The master drives results in; the slave (arbiter) accepts them and drives the bus.
interface cdb_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]        Req_Valid;
    logic [N_SRC*TAG_W-1:0]  Req_Tag;
    logic [N_SRC*DATA_W-1:0] Req_Data;
    logic [N_SRC-1:0]        Req_Ready;
    logic                    CDB_Valid;
    logic [TAG_W-1:0]        CDB_Tag;
    logic [DATA_W-1:0]       CDB_Value;
    logic [SRC_W-1:0]        CDB_Src;
    logic                    Err;

    modport master (
        output Req_Valid, Req_Tag, Req_Data,
        input  Req_Ready, CDB_Valid, CDB_Tag, CDB_Value, CDB_Src, Err
    );

    modport slave (
        input  Req_Valid, Req_Tag, Req_Data,
        output Req_Ready, CDB_Valid, CDB_Tag, CDB_Value, CDB_Src, Err
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per functional unit, round-robin grant of one
// result per cycle onto the registered (valid, tag, value) broadcast.
module cdb_slot #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_data,
    input  logic              grant,
    output logic              req_ready,
    output logic              full,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data,
    output logic              drop
);
    logic xfer, load;

    // A granted slot empties this edge, so it may refill in the same cycle.
    assign req_ready = !full | grant;
    assign xfer      = req_valid & req_ready;
    assign load      = xfer & (|req_tag);
    assign drop      = xfer & ~(|req_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            tag  <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            tag  <= req_tag;
            data <= req_data;
        end else if (grant) begin
            full <= 1'b0;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input logic         Clock,
    input logic         Reset,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]             full, grant, drop, slot_ready;
    logic [N_SRC-1:0][TAG_W-1:0]  slot_tag;
    logic [N_SRC-1:0][DATA_W-1:0] slot_data;
    logic [SRC_W-1:0]             rr, gidx, sidx;
    logic                         found;
    int                           idx;

    logic              cdb_valid, err;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [SRC_W-1:0]  cdb_src;

    for (genvar i = 0; i < N_SRC; i++) begin : g_slot
        cdb_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot (
            .clk      (Clock),
            .rst      (Reset),
            .req_valid(bus.Req_Valid[i]),
            .req_tag  (bus.Req_Tag[i*TAG_W +: TAG_W]),
            .req_data (bus.Req_Data[i*DATA_W +: DATA_W]),
            .grant    (grant[i]),
            .req_ready(slot_ready[i]),
            .full     (full[i]),
            .tag      (slot_tag[i]),
            .data     (slot_data[i]),
            .drop     (drop[i])
        );
    end

    // First full slot at or after rr, wrapping modulo N_SRC.
    always_comb begin
        grant = '0;
        gidx  = '0;
        sidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx  = (int'(rr) + k) % N_SRC;
            sidx = SRC_W'(idx);
            if (!found && full[sidx]) begin
                grant[sidx] = 1'b1;
                gidx        = sidx;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rr        <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            err       <= 1'b0;
        end else begin
            cdb_valid <= found;
            err       <= err | (|drop);
            if (found) begin
                cdb_tag   <= slot_tag[gidx];
                cdb_value <= slot_data[gidx];
                cdb_src   <= gidx;
                rr        <= (gidx == SRC_W'(N_SRC - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    assign bus.Req_Ready = slot_ready;
    assign bus.CDB_Valid = cdb_valid;
    assign bus.CDB_Tag   = cdb_tag;
    assign bus.CDB_Value = cdb_value;
    assign bus.CDB_Src   = cdb_src;
    assign bus.Err       = err;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order, refill
// under backpressure, tag-0 error and reset mid-operation.
module tb_cdb_arbiter;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 Clock = ~Clock;

    cdb_arbiter_if #(.N_SRC(4), .DATA_W(16), .TAG_W(3)) bus ();

    cdb_arbiter #(.N_SRC(4), .DATA_W(16), .TAG_W(3)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    wire [21:0] cdb_obs = {bus.CDB_Valid, bus.CDB_Src, bus.CDB_Tag, bus.CDB_Value};

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.Req_Valid = '0;
        bus.Req_Tag   = '0;
        bus.Req_Data  = '0;
    endtask

    task automatic drive(input int s, input logic [2:0] t, input logic [15:0] d);
        bus.Req_Valid[s]        = 1'b1;
        bus.Req_Tag[s*3 +: 3]   = t;
        bus.Req_Data[s*16 +: 16] = d;
    endtask

    task automatic apply_reset();
        idle();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle();
        drive(0, 3'd3, 16'h0303);
        step();
        step();
        checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.CDB_Valid); end
        checks++; if (bus.CDB_Tag !== 3'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", bus.CDB_Tag); end
        checks++; if (bus.CDB_Value !== 16'h0) begin failures++; $display("FAIL reset_value got=%h exp=0000", bus.CDB_Value); end
        checks++; if (bus.CDB_Src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", bus.CDB_Src); end
        checks++; if (bus.Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.Err); end
        checks++; if (bus.Req_Ready !== 4'b1111) begin failures++; $display("FAIL reset_ready got=%b exp=1111", bus.Req_Ready); end
        Reset = 1'b0;
        idle();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL reset_no_bcast cyc=%0d got=%b exp=0", c, bus.CDB_Valid); end
        end
    endtask

    task automatic test_single();
        apply_reset();
        drive(2, 3'd5, 16'h1234);
        step();
        idle();
        checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", bus.CDB_Valid); end
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd2, 3'd5, 16'h1234}) begin failures++; $display("FAIL single_bcast got=%h exp=%h", cdb_obs, {1'b1, 2'd2, 3'd5, 16'h1234}); end
        step();
        checks++; if (cdb_obs !== {1'b0, 2'd2, 3'd5, 16'h1234}) begin failures++; $display("FAIL single_hold got=%h exp=%h", cdb_obs, {1'b0, 2'd2, 3'd5, 16'h1234}); end
    endtask

    task automatic test_round_robin();
        logic [15:0] d;
        logic [21:0] exp;
        int s;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                d = 16'hA000 + 16'(r*16 + i);
                drive(i, 3'(i + 1), d);
            end
            step();
            idle();
            for (int k = 0; k < 4; k++) begin
                step();
                d   = 16'hA000 + 16'(r*16 + k);
                exp = {1'b1, 2'(k), 3'(k + 1), d};
                checks++; if (cdb_obs !== exp) begin failures++; $display("FAIL rr_pass%0d slot%0d got=%h exp=%h", r, k, cdb_obs, exp); end
            end
            step();
            checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL rr_idle%0d got=%b exp=0", r, bus.CDB_Valid); end
        end
        // A lone src1 grant leaves the pointer at 2.
        drive(1, 3'd6, 16'h0B01);
        step();
        idle();
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd1, 3'd6, 16'h0B01}) begin failures++; $display("FAIL rr_lone got=%h exp=%h", cdb_obs, {1'b1, 2'd1, 3'd6, 16'h0B01}); end
        for (int i = 0; i < 4; i++) drive(i, 3'(i + 1), 16'hC000 + 16'(i));
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            s   = (k + 2) % 4;
            exp = {1'b1, 2'(s), 3'(s + 1), 16'hC000 + 16'(s)};
            checks++; if (cdb_obs !== exp) begin failures++; $display("FAIL rr_from2 step%0d got=%h exp=%h", k, cdb_obs, exp); end
        end
    endtask

    task automatic test_back_to_back();
        // Broadcasts expected on edges 1..6; Req_Ready expected in cycles 0..4.
        logic [21:0] exp_b [6] = '{
            {1'b1, 2'd0, 3'd1, 16'h0100}, {1'b1, 2'd1, 3'd2, 16'h0200},
            {1'b1, 2'd0, 3'd1, 16'h0101}, {1'b1, 2'd1, 3'd2, 16'h0201},
            {1'b1, 2'd0, 3'd1, 16'h0102}, {1'b1, 2'd1, 3'd2, 16'h0202}};
        logic [1:0] exp_rdy [5] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10};
        int n0 = 0, n1 = 0;
        logic a0, a1;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            idle();
            if (n0 < 3) drive(0, 3'd1, 16'h0100 + 16'(n0));
            if (n1 < 3) drive(1, 3'd2, 16'h0200 + 16'(n1));
            #1;
            if (c < 5) begin
                checks++; if (bus.Req_Ready[1:0] !== exp_rdy[c]) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, bus.Req_Ready[1:0], exp_rdy[c]); end
            end
            a0 = bus.Req_Valid[0] & bus.Req_Ready[0];
            a1 = bus.Req_Valid[1] & bus.Req_Ready[1];
            step();
            if (a0) n0++;
            if (a1) n1++;
            if (c >= 1 && c <= 6) begin
                checks++; if (cdb_obs !== exp_b[c-1]) begin failures++; $display("FAIL b2b_bcast edge=%0d got=%h exp=%h", c, cdb_obs, exp_b[c-1]); end
            end else begin
                checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL b2b_idle edge=%0d got=%b exp=0", c, bus.CDB_Valid); end
            end
        end
        idle();
    endtask

    task automatic test_tag0_err();
        apply_reset();
        checks++; if (bus.Err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b exp=0", bus.Err); end
        drive(3, 3'd0, 16'hFFFF);
        #1;
        checks++; if (bus.Req_Ready[3] !== 1'b1) begin failures++; $display("FAIL err_ready got=%b exp=1", bus.Req_Ready[3]); end
        step();
        idle();
        checks++; if (bus.Err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus.Err); end
        step();
        checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL err_no_bcast got=%b exp=0", bus.CDB_Valid); end
        checks++; if (bus.Req_Ready !== 4'b1111) begin failures++; $display("FAIL err_slot_empty got=%b exp=1111", bus.Req_Ready); end
        drive(0, 3'd4, 16'h5555);
        step();
        idle();
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd0, 3'd4, 16'h5555}) begin failures++; $display("FAIL err_traffic got=%h exp=%h", cdb_obs, {1'b1, 2'd0, 3'd4, 16'h5555}); end
        checks++; if (bus.Err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.Err); end
        apply_reset();
        #1;
        checks++; if (bus.Err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus.Err); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) drive(i, 3'(i + 1), 16'hD000 + 16'(i));
        step();
        idle();
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd0, 3'd1, 16'hD000}) begin failures++; $display("FAIL mid_first got=%h exp=%h", cdb_obs, {1'b1, 2'd0, 3'd1, 16'hD000}); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++; if (bus.CDB_Valid !== 1'b0 || bus.Req_Ready !== 4'b1111) begin failures++; $display("FAIL mid_reset got=%b/%b exp=0/1111", bus.CDB_Valid, bus.Req_Ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (bus.CDB_Valid !== 1'b0) begin failures++; $display("FAIL mid_flushed cyc=%0d got=%b exp=0", c, bus.CDB_Valid); end
        end
        // Pointer back at 0: src0 must beat src2.
        drive(0, 3'd6, 16'h0E00);
        drive(2, 3'd7, 16'h0E02);
        step();
        idle();
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd0, 3'd6, 16'h0E00}) begin failures++; $display("FAIL mid_rr0 got=%h exp=%h", cdb_obs, {1'b1, 2'd0, 3'd6, 16'h0E00}); end
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd2, 3'd7, 16'h0E02}) begin failures++; $display("FAIL mid_rr2 got=%h exp=%h", cdb_obs, {1'b1, 2'd2, 3'd7, 16'h0E02}); end
        step();
        drive(1, 3'd7, 16'h0777);
        step();
        idle();
        step();
        checks++; if (cdb_obs !== {1'b1, 2'd1, 3'd7, 16'h0777}) begin failures++; $display("FAIL mid_fresh got=%h exp=%h", cdb_obs, {1'b1, 2'd1, 3'd7, 16'h0777}); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_tag0_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
